// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver. It takes in an asynchronous RX line and samples each bit at
// mid-bit. The assembled byte is presented with a sticky ready flag and a framing-error flag.
module uart_rx #(
    parameter int unsigned BAUD_CNT = 2604,
    parameter int unsigned HALF_CNT = BAUD_CNT / 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frame_err
);

    localparam int unsigned CW = $clog2(BAUD_CNT + 1);

    // The baud counter runs down to 0 inclusive.
    // Loading N-1 gives an interval of exactly N cycles.
    localparam logic [CW-1:0] BAUD_LOAD = CW'(BAUD_CNT - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(HALF_CNT - 1);
    localparam logic [CW-1:0] BAUD_ONE  = CW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StRecv
    } state_e;

    state_e         state_q;
    logic           rx_meta_q;
    logic           rx_s_q;
    logic           rx_prev_q;
    logic [CW-1:0]  baud_q;
    logic [3:0]     bit_q;
    logic [7:0]     shreg_q;
    logic           fall;

    // Double-flop synchronizer plus edge-history flop.
    // All three preset high, so coming out of reset cannot look like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign fall = rx_prev_q & ~rx_s_q;

    // Receive FSM with registered outputs.
    // A byte-complete set of rdy overrides a same-cycle clr_rdy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            baud_q    <= '0;
            bit_q     <= 4'd0;
            shreg_q   <= 8'h00;
            rx_data   <= 8'h00;
            rdy       <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (clr_rdy) begin
                rdy <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (fall) begin
                        baud_q    <= HALF_LOAD;
                        state_q   <= StStart;
                        rdy       <= 1'b0;
                        frame_err <= 1'b0;
                    end
                end
                StStart: begin
                    if (baud_q == '0) begin
                        if (rx_s_q) begin
                            // Line went high again before mid-start: treat it as a glitch.
                            state_q <= StIdle;
                        end else begin
                            baud_q  <= BAUD_LOAD;
                            bit_q   <= 4'd0;
                            state_q <= StRecv;
                        end
                    end else begin
                        baud_q <= baud_q - BAUD_ONE;
                    end
                end
                StRecv: begin
                    if (baud_q == '0) begin
                        baud_q <= BAUD_LOAD;
                        bit_q  <= bit_q + 4'd1;
                        if (bit_q == 4'd8) begin
                            // Stop-bit sample: deliver the byte even if the stop bit is 0.
                            rx_data   <= shreg_q;
                            frame_err <= ~rx_s_q;
                            rdy       <= 1'b1;
                            state_q   <= StIdle;
                        end else begin
                            shreg_q <= {rx_s_q, shreg_q[7:1]};
                        end
                    end else begin
                        baud_q <= baud_q - BAUD_ONE;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
